// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD frame-buffer prefetch path
package lcd_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, CHECK, REQ, XFER, DRAIN, DONE} state_t;
  typedef logic [10:0] disp_dim_t;
  function automatic int ppw(input int data_w);
    return data_w / 16;
  endfunction
  function automatic int ppw_log2(input int data_w);
    return $clog2(data_w / 16);
  endfunction
endpackage

// File: rtl/lcd_vsync_edge.sv
// lcd_vsync_edge: registers out_vsync and flags its rising edge as frame start
module lcd_vsync_edge (
  input  logic lcd_clk,
  input  logic sys_rst_n,
  input  logic out_vsync,
  output logic fs
);
  logic vs_q;
  // reset high so a vsync already asserted at reset release is not taken as an edge
  always_ff @(posedge lcd_clk or negedge sys_rst_n)
    if (!sys_rst_n) vs_q <= 1'b1;
    else vs_q <= out_vsync;
  assign fs = out_vsync & ~vs_q;
endmodule

// File: rtl/lcd_fb_prefetch_ctrl.sv
// lcd_fb_prefetch_ctrl: frame-buffer burst scheduler feeding the LCD pixel FIFO (optional stats: LCD_PREFETCH_STATS_EN)
module lcd_fb_prefetch_ctrl
  import lcd_pkg::*;
#(
  parameter int          DATA_W    = 128,
  parameter int          ADDR_W    = 28,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          BURST_LEN = 64,
  parameter int          FIFO_AW   = 9,
  parameter int          LOW_WM    = 256,
  parameter int          FLUSH_CYC = 4
) (
  input  logic               lcd_clk,
  input  logic               sys_rst_n,
  input  disp_dim_t          h_disp,
  input  disp_dim_t          v_disp,
  input  logic               out_vsync,
  input  logic               data_req,
  input  logic [FIFO_AW:0]   fifo_level,
  input  logic               fifo_empty,
  output logic               rd_req,
  input  logic               rd_ack,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [7:0]         rd_len,
  input  logic               rd_done,
  output logic               fifo_flush,
  output logic               frame_busy,
  output logic               underflow
`ifdef LCD_PREFETCH_STATS_EN
  ,
  output logic [15:0]        ufl_cnt,
  output logic [15:0]        frame_cnt
`endif
);
  localparam int                PPW_L2 = ppw_log2(DATA_W);
  localparam int                FC_W   = $clog2(FLUSH_CYC) + 1;
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [21:0]       BL     = 22'(BURST_LEN);
  localparam logic [FIFO_AW:0]  WM     = (FIFO_AW+1)'(LOW_WM);
  localparam logic [FC_W-1:0]   FC_END = FC_W'(FLUSH_CYC - 1);

  state_t            state_q, state_d;
  logic [21:0]       words_q, words_d, rem_q, rem_d, prod;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              busy_q, busy_d, ufl_q, ufl_d, fs, ufl_hit;

  lcd_vsync_edge u_vsync_edge (
    .lcd_clk   (lcd_clk),
    .sys_rst_n (sys_rst_n),
    .out_vsync (out_vsync),
    .fs        (fs)
  );

  assign prod    = 22'(h_disp) * 22'(v_disp);
  assign ufl_hit = data_req & fifo_empty & (busy_q | state_q == DONE);

  // frame-start latching of the word count, underflow flag and burst FSM next state
  always_comb begin
    words_d = (fs && state_q != FLUSH && state_q != DRAIN) ? prod >> PPW_L2 : words_q;
    ufl_d   = (state_q == FLUSH) ? 1'b0 : ufl_q | ufl_hit;
    state_d = state_q;
    fcnt_d  = fcnt_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: if (fs) state_d = FLUSH;
      FLUSH: begin
        busy_d = 1'b1;
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == FC_END) begin
          state_d = CHECK;
          fcnt_d  = '0;
          addr_d  = BASE;
          rem_d   = words_q;
        end
      end
      CHECK:
        if (fs) state_d = FLUSH;
        else if (rem_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
        end else if (fifo_level <= WM) begin
          state_d = REQ;
          len_d   = 8'((rem_q < BL) ? rem_q : BL);
        end
      REQ:
        if (rd_ack) begin
          state_d = fs ? DRAIN : XFER;
          addr_d  = addr_q + ADDR_W'(len_q);
          rem_d   = rem_q - 22'(len_q);
        end else if (fs) state_d = FLUSH;
      // a frame start coinciding with the final beat needs no drain: nothing is left in flight
      XFER:
        if (rd_done) state_d = fs ? FLUSH : CHECK;
        else if (fs) state_d = DRAIN;
      DRAIN: if (rd_done) state_d = FLUSH;
      default: state_d = IDLE;
    endcase
  end

  // controller state registers
  always_ff @(posedge lcd_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= IDLE;
      words_q <= '0;
      rem_q   <= '0;
      addr_q  <= BASE;
      len_q   <= '0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      ufl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
      ufl_q   <= ufl_d;
    end

  assign rd_req     = state_q == REQ;
  assign rd_addr    = addr_q;
  assign rd_len     = len_q;
  assign fifo_flush = state_q == FLUSH;
  assign frame_busy = busy_q;
  assign underflow  = ufl_q;

`ifdef LCD_PREFETCH_STATS_EN
  logic [15:0] ufl_cnt_q, ufl_cnt_d, frame_cnt_q, frame_cnt_d;

  // underflow cycles saturate and restart with the flush; completed frames wrap
  always_comb begin
    ufl_cnt_d   = (state_q == FLUSH) ? '0 : ufl_cnt_q + 16'((ufl_hit && ufl_cnt_q != '1) ? 1 : 0);
    frame_cnt_d = frame_cnt_q + 16'((state_d == DONE && state_q != DONE) ? 1 : 0);
  end

  // statistics registers
  always_ff @(posedge lcd_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      ufl_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      ufl_cnt_q   <= ufl_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end

  assign ufl_cnt   = ufl_cnt_q;
  assign frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_lcd_fb_prefetch_ctrl.sv
// tb_lcd_fb_prefetch_ctrl: scoreboard bench for the frame-buffer prefetch controller
module tb_lcd_fb_prefetch_ctrl;
  localparam int BASE = 256;
  localparam int WM   = 256;

  logic        lcd_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [10:0] h_disp = '0, v_disp = '0;
  logic        out_vsync = 1'b1, data_req = 1'b0, fifo_empty = 1'b0, rd_ack = 1'b0, rd_done = 1'b0;
  logic [9:0]  fifo_level = '0;
  logic        rd_req, fifo_flush, frame_busy, underflow;
  logic [27:0] rd_addr;
  logic [7:0]  rd_len;
`ifdef LCD_PREFETCH_STATS_EN
  logic [15:0] ufl_cnt, frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [35:0] sb[$];

  always #5 lcd_clk = ~lcd_clk;

  lcd_fb_prefetch_ctrl #(.BASE_ADDR(BASE)) dut (
    .lcd_clk    (lcd_clk),
    .sys_rst_n  (sys_rst_n),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .out_vsync  (out_vsync),
    .data_req   (data_req),
    .fifo_level (fifo_level),
    .fifo_empty (fifo_empty),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_addr    (rd_addr),
    .rd_len     (rd_len),
    .rd_done    (rd_done),
    .fifo_flush (fifo_flush),
    .frame_busy (frame_busy),
    .underflow  (underflow)
`ifdef LCD_PREFETCH_STATS_EN
    ,
    .ufl_cnt    (ufl_cnt),
    .frame_cnt  (frame_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge lcd_clk);
  endtask

  task automatic push_frame(input int h, input int v);
    int w = (h * v) >> 3;
    logic [27:0] a = 28'(BASE);
    while (w > 0) begin
      int l = (w < 64) ? w : 64;
      sb.push_back({a, 8'(l)});
      a += 28'(l);
      w -= l;
    end
  endtask

  task automatic start_frame(input int h, input int v, output int fl, output int lat);
    h_disp = 11'(h);
    v_disp = 11'(v);
    fl = 0;
    lat = 0;
    out_vsync = 1'b0;
    tick();
    out_vsync = 1'b1;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      tick();
      fl += int'(fifo_flush);
      if (rd_req) lat = n;
    end
    out_vsync = 1'b0;
  endtask

  task automatic serve(input int hold, input bit skip_done);
    int n = 0;
    bit ok = 1'b1;
    logic [35:0] e;
    logic [27:0] a0;
    logic [7:0] l0;
    while (!rd_req && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(rd_req), 1);
    if (!rd_req) return;
    a0 = rd_addr;
    l0 = rd_len;
    repeat (hold) begin
      tick();
      ok = ok & (rd_req === 1'b1 && rd_addr === a0 && rd_len === l0);
    end
    if (hold > 0) chk("hold_stable", 32'(ok), 1);
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    chk("rd_addr", 32'(rd_addr), 32'(e[35:8]));
    chk("rd_len", 32'(rd_len), 32'(e[7:0]));
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    chk("req_drop", 32'(rd_req), 0);
    if (!skip_done) begin
      repeat (2) tick();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int fl, lat, n;
    bit bad;
    repeat (3) tick();
    chk("rst_req", 32'(rd_req), 0);
    chk("rst_addr", 32'(rd_addr), BASE);
    chk("rst_len", 32'(rd_len), 0);
    chk("rst_flush", 32'(fifo_flush), 0);
    chk("rst_busy", 32'(frame_busy), 0);
    chk("rst_ufl", 32'(underflow), 0);
    sys_rst_n = 1'b1;
    fl = 0;
    repeat (8) begin
      tick();
      fl += int'(fifo_flush);
    end
    chk("rst_vs_no_fs", 32'(fl), 0);
    chk("rst_vs_no_req", 32'(rd_req), 0);

    push_frame(480, 136);
    start_frame(480, 136, fl, lat);
    chk("fs_flush_w", 32'(fl), 4);
    chk("fs_lat", 32'(lat), 6);
    chk("busy_on", 32'(frame_busy), 1);
    for (int i = 0; i < 128; i++) serve((i == 3) ? 20 : 0, 1'b0);
    repeat (3) tick();
    chk("done_busy", 32'(frame_busy), 0);
    chk("done_addr", 32'(rd_addr), BASE + 8160);
    chk("done_req", 32'(rd_req), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    data_req = 1'b1;
    fifo_empty = 1'b1;
    repeat (3) tick();
    data_req = 1'b0;
    fifo_empty = 1'b0;
    repeat (5) tick();
    chk("ufl_sticky", 32'(underflow), 1);
`ifdef LCD_PREFETCH_STATS_EN
    chk("ufl_cnt", 32'(ufl_cnt), 3);
`endif

    fifo_level = 10'(WM + 1);
    push_frame(16, 8);
    start_frame(16, 8, fl, lat);
    chk("wm_flush_w", 32'(fl), 4);
    chk("ufl_cleared", 32'(underflow), 0);
`ifdef LCD_PREFETCH_STATS_EN
    chk("ufl_cnt_clr", 32'(ufl_cnt), 0);
`endif
    repeat (10) tick();
    chk("wm_block", 32'(rd_req), 0);
    fifo_level = 10'(WM);
    tick();
    chk("wm_req", 32'(rd_req), 1);
    serve(0, 1'b0);
    fifo_level = '0;
    repeat (3) tick();
    chk("wm_done_busy", 32'(frame_busy), 0);

    push_frame(480, 136);
    start_frame(480, 136, fl, lat);
    chk("f3_lat", 32'(lat), 6);
    serve(0, 1'b1);
    out_vsync = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      out_vsync = 1'b0;
      bad = bad | rd_req | fifo_flush;
    end
    chk("drain_quiet", 32'(bad), 0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    fl = int'(fifo_flush);
    repeat (7) begin
      tick();
      fl += int'(fifo_flush);
    end
    chk("drain_flush_w", 32'(fl), 4);
    chk("drain_addr", 32'(rd_addr), BASE);
    sb.delete();
    push_frame(480, 136);
    serve(0, 1'b0);
    n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    chk("req2", 32'(rd_req), 1);
    chk("req2_addr", 32'(rd_addr), BASE + 64);
    sb.delete();

    start_frame(0, 0, fl, lat);
    chk("zero_flush_w", 32'(fl), 4);
    chk("zero_no_req", 32'(lat), 0);
    chk("zero_busy", 32'(frame_busy), 0);
    chk("zero_addr", 32'(rd_addr), BASE);
`ifdef LCD_PREFETCH_STATS_EN
    chk("frame_cnt", 32'(frame_cnt), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
